// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b instruction fetch. Owns the PC and the I-side memory
// port (mem1), and registers fetched words into the IF/ID pipeline register.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mem1_address/read          fetch request; read stays high until mem1_resp
//   mem1_resp/rdata            one-cycle completion pulse with the word
//   stall                      downstream not taking IF/ID this cycle
//   redirect/redirect_pc       one-cycle redirect pulse and target (bit 0 dropped)
//   ifid_valid/ir/pc           IF/ID register; ir=0 (NOP) when invalid, pc=addr+2
//   opcode, irbits             ifid_ir[15:12] / ifid_ir[11:0]
//
// Optional feature macro FETCH_STATS_EN adds saturating counters
// stat_fetched / stat_squashed (words delivered to IF/ID / words discarded).
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem1_address,
  output logic        mem1_read,
  input  logic        mem1_resp,
  input  logic [15:0] mem1_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ifid_valid,
  output logic [15:0] ifid_ir,
  output logic [15:0] ifid_pc,
  output logic [3:0]  opcode,
  output logic [11:0] irbits
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stat_fetched,
  output logic [15:0] stat_squashed
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } ifid_t;

  state_t      state;
  logic [15:0] fetch_addr;
  logic [15:0] pc;
  ifid_t       hold;
  ifid_t       ifid;
  logic        ifid_v;

  logic [15:0] tgt;
  logic [15:0] next_addr;
  logic        slot_free;

  assign tgt       = {redirect_pc[15:1], 1'b0};
  assign next_addr = fetch_addr + 16'd2;   // wraps FFFE -> 0000
  assign slot_free = !ifid_v || !stall;

  // Outputs are forced to zero while reset is high so the reset cycle itself
  // issues nothing and presents an empty IF/ID, independent of prior state.
  assign mem1_read    = !reset && (state != HOLD);
  assign mem1_address = reset ? 16'h0000 : fetch_addr;
  assign ifid_valid   = !reset && ifid_v;
  assign ifid_ir      = reset ? 16'h0000 : ifid.ir;
  assign ifid_pc      = reset ? 16'h0000 : ifid.pc;
  assign opcode       = ifid_ir[15:12];
  assign irbits       = ifid_ir[11:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      fetch_addr <= RESET_PC;
      pc         <= RESET_PC;
      hold       <= '0;
      ifid       <= '0;
      ifid_v     <= 1'b0;
    end else if (redirect) begin
      // Redirect beats stall: IF/ID and buffer are flushed unconditionally.
      ifid_v  <= 1'b0;
      ifid.ir <= 16'h0000;
      hold    <= '0;
      pc      <= tgt;
      if (state != HOLD && !mem1_resp) begin
        // Request still in flight: it must complete at its old address.
        state <= DRAIN;
      end else begin
        // No request in flight (HOLD) or it completes now: data dropped,
        // fetch restarts at the target.
        fetch_addr <= tgt;
        state      <= FETCH;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (mem1_resp) begin
            fetch_addr <= next_addr;
            pc         <= next_addr;
            if (slot_free) begin
              ifid   <= '{ir: mem1_rdata, pc: next_addr};
              ifid_v <= 1'b1;
            end else begin
              hold  <= '{ir: mem1_rdata, pc: next_addr};
              state <= HOLD;
            end
          end else if (slot_free) begin
            ifid_v  <= 1'b0;
            ifid.ir <= 16'h0000;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid   <= hold;
            ifid_v <= 1'b1;
            state  <= FETCH;
          end
        end
        DRAIN: begin
          // pc already holds the redirect target.
          if (mem1_resp) begin
            fetch_addr <= pc;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fet_cnt, sq_cnt;
  logic [1:0]  sq_inc;
  logic        fet_inc;
  logic [16:0] sq_sum, fet_sum;

  always_comb begin
    sq_inc  = 2'd0;
    fet_inc = 1'b0;
    if (redirect) begin
      sq_inc = {1'b0, ifid_v} + {1'b0, state == HOLD}
             + {1'b0, state != HOLD && mem1_resp};
    end else begin
      sq_inc  = {1'b0, state == DRAIN && mem1_resp};
      fet_inc = (state == FETCH && mem1_resp && slot_free) ||
                (state == HOLD && !stall);
    end
  end

  assign sq_sum  = {1'b0, sq_cnt} + {15'd0, sq_inc};
  assign fet_sum = {1'b0, fet_cnt} + {16'd0, fet_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      fet_cnt <= '0;
      sq_cnt  <= '0;
    end else begin
      fet_cnt <= fet_sum[16] ? 16'hFFFF : fet_sum[15:0];
      sq_cnt  <= sq_sum[16]  ? 16'hFFFF : sq_sum[15:0];
    end
  end

  assign stat_fetched  = reset ? 16'h0000 : fet_cnt;
  assign stat_squashed = reset ? 16'h0000 : sq_cnt;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LC-3b pipeline; owns the PC and the I-side memory port (mem1), and registers fetched instructions into the IF/ID pipeline register.
- Directly upstream of the control-word generator. The generator consumes opcode/irbits decoded from the IF/ID register.
- Handles downstream stalls with a one-entry holding buffer, and redirects (branch/JMP/JSR/TRAP targets) with squash of in-flight fetches.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  synchronous, active-high reset.
mem1_address  output  16  fetch address; valid while mem1_read=1.
mem1_read  output  1  fetch request; held high until mem1_resp.
mem1_resp  input  1  one-cycle pulse: mem1_rdata valid, request complete.
mem1_rdata  input  16  fetched instruction word.
stall  input  1  downstream not accepting IF/ID this cycle.
redirect  input  1  one-cycle pulse: discard younger work, fetch from redirect_pc.
redirect_pc  input  16  redirect target; bit 0 forced to 0.
ifid_valid  output  1  IF/ID holds a live instruction.
ifid_ir  output  16  IF/ID instruction; 16'h0000 (BR never, a NOP) when invalid.
ifid_pc  output  16  address of ifid_ir plus 2 (for PC-relative/JSR link).
opcode  output  4  ifid_ir[15:12], combinational.
irbits  output  12  ifid_ir[11:0], combinational.

Behaviour:
- Internal registers:
  - fetch_addr: address of the outstanding or next fetch.
  - pc: architectural next-fetch address.
  - hold_ir / hold_pc: holding buffer.
  - state: FETCH, HOLD or DRAIN.
- Reset, effective the cycle reset is high:
  - pc = fetch_addr = RESET_PC; state = FETCH.
  - ifid_valid=0, ifid_ir=0, ifid_pc=0, buffer cleared.
  - mem1_read=0 during reset. First request is issued the cycle after reset deasserts.
  - Reset mid-request abandons the request with no drain.
- Consume rule: the IF/ID slot is free this cycle if ifid_valid=0 or stall=0.
- FETCH state:
  - Drive mem1_read=1, mem1_address=fetch_addr.
  - No resp, slot free: ifid_valid<=0 (bubble); ifid_ir<=0.
  - No resp, slot not free: IF/ID holds.
  - resp and slot free: ifid_ir<=mem1_rdata; ifid_pc<=fetch_addr+2; ifid_valid<=1; fetch_addr<=fetch_addr+2; stay FETCH. Back-to-back fetches carry no idle cycle.
  - resp and slot not free: hold_ir<=mem1_rdata; hold_pc<=fetch_addr+2; fetch_addr+=2; go HOLD.
- HOLD state:
  - mem1_read=0.
  - When stall=0: IF/ID<=buffer (valid=1); go FETCH, issuing the next request that same cycle.
- DRAIN state:
  - mem1_read=1 with the old address. Address must not change mid-request.
  - On resp: discard data; fetch_addr<=pc (the redirect target); go FETCH.
  - IF/ID stays invalid throughout.
- Redirect has highest priority and overrides stall:
  - ifid_valid<=0, ifid_ir<=0 in the next cycle; buffer discarded; pc<=redirect_pc&16'hFFFE.
  - FETCH with no resp this cycle: go DRAIN.
  - FETCH with resp this cycle: discard the data; fetch_addr<=target; stay FETCH.
  - HOLD: fetch_addr<=target; go FETCH.
  - DRAIN: update pc only; stay DRAIN.
- pc tracks fetch_addr except while DRAIN.
- Address arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000.
- Latency: request issued in cycle N with resp in cycle N+k puts the instruction on IF/ID outputs in cycle N+k+1.

Optional Feature:
FETCH_STATS_EN
- Defined:
  - Adds outputs stat_fetched[15:0] and stat_squashed[15:0]. Both are saturating counters, cleared by reset.
  - stat_fetched increments once per instruction loaded into IF/ID.
  - stat_squashed increments once per discarded word (resp during DRAIN, resp coincident with redirect, valid IF/ID or buffer flushed by redirect). Multiple discards in one cycle count individually, saturating at 16'hFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, RESET_PC=0, mem responds 1 cycle after each request with words 16'h1234, 16'h5678 -> mem1_address 0 then 2; IF/ID shows 16'h1234/pc 0002, then 16'h5678/pc 0004; opcode=4'h1, irbits=12'h234 first.
2. Stall held 3 cycles while a resp arrives -> IF/ID unchanged, state HOLD, mem1_read=0; on stall release the buffered word appears next cycle and a new request is issued the same cycle.
3. Redirect to 16'h0101 while a request to 16'h0006 is outstanding -> mem1_address stays 0006 until resp; data discarded; next request is to 16'h0100; ifid_valid=0 meanwhile.
4. Redirect coincident with resp, and redirect during stall with ifid_valid=1 -> both words dropped, ifid_ir=0, next fetch at target, no stale instruction ever valid.
5. fetch_addr=16'hFFFE fetch completes -> ifid_pc=16'h0000, next request to 16'h0000.
6. Reset asserted mid-request, and (with FETCH_STATS_EN) scenario 3 -> all outputs 0, mem1_read=0 the reset cycle; stat_squashed=1, stat_fetched counts only delivered words.
